// File: rtl/cl_checker.sv
// cl_checker: exhaustive self-test sequencer for the cl logic cell.
// Ports: clk, rst_n, start in; cl_out from cl; drv_a/b/s to cl;
//        busy, done, pass, err_cnt, fail_valid, fail_idx status out.
module cl_checker #(
    parameter int SETTLE = 2,
    parameter int ERRW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            cl_out,
    output logic            drv_a,
    output logic            drv_b,
    output logic [1:0]      drv_s,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [ERRW-1:0] err_cnt,
    output logic            fail_valid,
    output logic [3:0]      fail_idx
);

    typedef enum logic [2:0] {
        IDLE, APPLY, WAIT, CHECK, FIN
    } state_t;

    localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam logic [ERRW-1:0] ERR_MAX = '1;

    state_t          state;
    logic [3:0]      idx;
    logic [CW-1:0]   cnt;
    logic            golden;
    logic            mism;
    logic [ERRW-1:0] err_nxt;

    // idx = {s, b, a}
    always_comb begin
        golden = 1'b0;
        unique case (idx[3:2])
            2'b00: golden = idx[0] & idx[1];
            2'b01: golden = idx[0] | idx[1];
            2'b10: golden = idx[0] ^ idx[1];
            2'b11: golden = ~idx[0];
        endcase
    end

    assign mism    = (cl_out != golden);
    assign err_nxt = (mism && (err_cnt != ERR_MAX)) ?
                     err_cnt + 1'b1 : err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            drv_a      <= 1'b0;
            drv_b      <= 1'b0;
            drv_s      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_idx   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        err_cnt    <= '0;
                        fail_valid <= 1'b0;
                        fail_idx   <= '0;
                        pass       <= 1'b0;
                        idx        <= '0;
                        // vector 0 and busy become visible with APPLY
                        {drv_s, drv_b, drv_a} <= 4'd0;
                        busy       <= 1'b1;
                        state      <= APPLY;
                    end
                end
                APPLY: begin
                    cnt <= CW'(SETTLE);
                    if (SETTLE == 0) state <= CHECK;
                    else             state <= WAIT;
                end
                WAIT: begin
                    if (cnt == CW'(1)) state <= CHECK;
                    else               cnt   <= cnt - 1'b1;
                end
                CHECK: begin
                    err_cnt <= err_nxt;
                    if (mism && !fail_valid) begin
                        fail_idx   <= idx;
                        fail_valid <= 1'b1;
                    end
                    if (idx == 4'd15) begin
                        done  <= 1'b1;
                        pass  <= (err_nxt == '0);
                        busy  <= 1'b0;
                        {drv_s, drv_b, drv_a} <= 4'd0;
                        state <= FIN;
                    end else begin
                        idx   <= idx + 4'd1;
                        // next vector appears together with APPLY
                        {drv_s, drv_b, drv_a} <= idx + 4'd1;
                        state <= APPLY;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cl_checker.sv
// tb_cl_checker: scoreboard bench for cl_checker.
// Instance a: SETTLE=2, ERRW=5; instance b: SETTLE=0, ERRW=3.
module tb_cl_checker;

    typedef struct packed {
        logic       pass;
        logic [4:0] err;
        logic       fv;
        logic [3:0] fidx;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    int   mode_a = 0;
    int   mode_b = 0;

    logic       a_da, a_db, a_busy, a_done, a_pass, a_fv, a_out;
    logic [1:0] a_ds;
    logic [4:0] a_err;
    logic [3:0] a_fidx;
    logic       b_da, b_db, b_busy, b_done, b_pass, b_fv, b_out;
    logic [1:0] b_ds;
    logic [2:0] b_err;
    logic [3:0] b_fidx;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] q_vec[$];
    res_t       q_res[$];
    res_t       q_res_b[$];

    function automatic logic gold(logic a, logic b, logic [1:0] s);
        case (s)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~a;
        endcase
    endfunction

    // 0 correct, 1 s=10 computes OR, 2 stuck 0, 3 stuck 1
    function automatic logic cl_fn(int m, logic a, logic b, logic [1:0] s);
        case (m)
            1:       return (s == 2'b10) ? (a | b) : gold(a, b, s);
            2:       return 1'b0;
            3:       return 1'b1;
            default: return gold(a, b, s);
        endcase
    endfunction

    function automatic res_t exp_res(int m, int errw);
        res_t r;
        int n;
        int mx;
        logic a, b;
        logic [1:0] s;
        r = '0;
        n = 0;
        mx = (1 << errw) - 1;
        for (int i = 0; i < 16; i++) begin
            a = i[0];
            b = i[1];
            s = i[3:2];
            if (cl_fn(m, a, b, s) !== gold(a, b, s)) begin
                if (n == 0) r.fidx = 4'(i);
                n++;
            end
        end
        r.fv   = (n > 0);
        r.err  = 5'((n > mx) ? mx : n);
        r.pass = (n == 0);
        return r;
    endfunction

    assign a_out = cl_fn(mode_a, a_da, a_db, a_ds);
    assign b_out = cl_fn(mode_b, b_da, b_db, b_ds);

    cl_checker #(.SETTLE(2), .ERRW(5)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .cl_out(a_out),
        .drv_a(a_da), .drv_b(a_db), .drv_s(a_ds),
        .busy(a_busy), .done(a_done), .pass(a_pass),
        .err_cnt(a_err), .fail_valid(a_fv), .fail_idx(a_fidx)
    );

    cl_checker #(.SETTLE(0), .ERRW(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .cl_out(b_out),
        .drv_a(b_da), .drv_b(b_db), .drv_s(b_ds),
        .busy(b_busy), .done(b_done), .pass(b_pass),
        .err_cnt(b_err), .fail_valid(b_fv), .fail_idx(b_fidx)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Full SETTLE=2 run on instance a, checked cycle by cycle.
    task automatic run_a(input int m, input bit hold);
        res_t e;
        res_t got;
        logic [3:0] v;
        mode_a = m;
        q_res.push_back(exp_res(m, 5));
        for (int i = 0; i < 16; i++) q_vec.push_back(4'(i));
        start_a = 1'b1;
        tick;
        if (!hold) start_a = 1'b0;
        n_cmp++;
        if ({a_pass, a_err, a_fv, a_fidx} !== 11'd0) begin
            n_bad++;
            $display("FAIL clear: got %h want 000",
                     {a_pass, a_err, a_fv, a_fidx});
        end
        for (int k = 0; k < 16; k++) begin
            v = q_vec.pop_front();
            for (int c = 0; c < 4; c++) begin
                n_cmp++;
                if ({a_busy, a_done, a_ds, a_db, a_da} !== {2'b10, v}) begin
                    n_bad++;
                    $display("FAIL vec%0d.%0d: got %b want %b", k, c,
                             {a_busy, a_done, a_ds, a_db, a_da},
                             {2'b10, v});
                end
                tick;
            end
        end
        n_cmp++;
        if ({a_busy, a_done, a_ds, a_db, a_da} !== 6'b010000) begin
            n_bad++;
            $display("FAIL fin: got %b want 010000",
                     {a_busy, a_done, a_ds, a_db, a_da});
        end
        e   = q_res.pop_front();
        got = {a_pass, a_err, a_fv, a_fidx};
        n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL res m%0d: got %h want %h", m, got, e);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #20;
        n_cmp++;
        if ({a_da, a_db, a_ds, a_busy, a_done, a_pass, a_err, a_fv, a_fidx,
             b_da, b_db, b_ds, b_busy, b_done, b_pass, b_err, b_fv, b_fidx}
            !== '0) begin
            n_bad++;
            $display("FAIL reset: outputs not zero a=%b b=%b",
                     {a_da, a_db, a_ds, a_busy, a_done, a_pass},
                     {b_da, b_db, b_ds, b_busy, b_done, b_pass});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        tick;
        n_cmp++;
        if ({a_busy, b_busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL idle: got %b want 00", {a_busy, b_busy});
        end
    endtask

    task automatic test_correct;
        run_a(0, 1'b0);
        tick;
    endtask

    task automatic test_fault_or;
        run_a(1, 1'b0);
        tick;
    endtask

    task automatic test_stuck0;
        run_a(2, 1'b0);
        tick;
    endtask

    task automatic test_saturate;
        int cyc;
        res_t e;
        res_t got;
        int ml[2] = '{3, 0};
        for (int j = 0; j < 2; j++) begin
            mode_b = ml[j];
            q_res_b.push_back(exp_res(ml[j], 3));
            start_b = 1'b1;
            tick;
            start_b = 1'b0;
            cyc = 1;
            while (b_done !== 1'b1 && cyc < 100) begin
                tick;
                cyc++;
            end
            n_cmp++;
            if (cyc != 33) begin
                n_bad++;
                $display("FAIL b_done_time: got %0d want 33", cyc);
            end
            e   = q_res_b.pop_front();
            got = {b_pass, 2'b00, b_err, b_fv, b_fidx};
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL b_res m%0d: got %h want %h", ml[j], got, e);
            end
            tick;
            tick;
        end
    endtask

    task automatic test_back_to_back;
        res_t e1;
        e1 = exp_res(2, 5);
        start_a = 1'b1;
        run_a(2, 1'b1);
        mode_a = 0;
        tick;
        n_cmp++;
        if ({a_busy, a_done, a_err} !== {2'b00, e1.err}) begin
            n_bad++;
            $display("FAIL after_done: got %b want %b",
                     {a_busy, a_done, a_err}, {2'b00, e1.err});
        end
        run_a(0, 1'b1);
        start_a = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        n_cmp++;
        if ({a_busy, a_pass} !== 2'b01) begin
            n_bad++;
            $display("FAIL no_rerun: got %b want 01", {a_busy, a_pass});
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        mode_a = 0;
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        for (int i = 0; i < 20; i++) tick;
        n_cmp++;
        if ({a_busy, a_ds, a_db, a_da} !== 5'b10101) begin
            n_bad++;
            $display("FAIL idx5: got %b want 10101",
                     {a_busy, a_ds, a_db, a_da});
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({a_da, a_db, a_ds, a_busy, a_done, a_pass, a_err, a_fv, a_fidx}
            !== '0) begin
            n_bad++;
            $display("FAIL mid_reset: got %b want 0",
                     {a_da, a_db, a_ds, a_busy, a_done, a_pass});
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (a_busy !== 1'b0 || a_done !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL stay_idle: got %0d active cycles want 0", seen);
        end
        run_a(0, 1'b0);
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_correct;
        test_fault_or;
        test_stuck0;
        test_saturate;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
